// File: rtl/mul_pkg.sv
// Shared definitions for the iterative LEGv8 multiplier: op codes, FSM states
// and the fixed iteration/register constants.
package mul_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;

    localparam int XZR_ADDR = 31;
    localparam int ITER     = 64;
    localparam int CNT_W    = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/mul_shift_add_datapath.sv
// Radix-2 shift-add datapath: operand latch with SMULH magnitude prep, 129-bit
// accumulator step, iteration counter and final sign fix / result select.
module mul_shift_add_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_neg;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_fixed;

    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
    // exactly right when read as unsigned.
    assign w_signed = (i_op == OP_SMULH);
    assign w_mag_a  = (w_signed && i_op_a[WIDTH-1]) ? ('0 - i_op_a) : i_op_a;
    assign w_mag_b  = (w_signed && i_op_b[WIDTH-1]) ? ('0 - i_op_b) : i_op_b;

    // The multiplier lives in r_lo and is shifted out as product bits shift in.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);

    assign o_last  = (r_cnt == CNT_W'(ITER - 1));
    assign w_prod  = {r_hi, r_lo};
    assign w_fixed = r_neg ? ('0 - w_prod) : w_prod;
    assign o_result = (r_op == OP_UMULH || r_op == OP_SMULH) ?
                      w_fixed[2*WIDTH-1:WIDTH] : w_fixed[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_neg   <= 1'b0;
        end else if (i_load) begin
            r_mcand <= w_mag_a;
            r_lo    <= w_mag_b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_op    <= i_op;
            r_neg   <= w_signed && (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
        end else if (i_step) begin
            r_hi  <= w_sum[WIDTH:1];
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_writeback_unit.sv
// Iterative MUL/UMULH/SMULH unit that writes its result straight into the
// register file write port; control FSM and registered write-port outputs.
module mul_writeback_unit
    import mul_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int ADDR_W       = 5,
    parameter int XZR_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    output logic              busy,
    output logic              done,
    output logic              write,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [WIDTH-1:0]  wrData,
    output logic [1:0]        dbg_state
);

    // Handshake: start is accepted only while busy is low (IDLE); busy then
    // stays high through CALC/FIX/WB, and done pulses for the single WB cycle
    // alongside the write-port signals. Starts seen while busy are dropped.
    state_t            r_state;
    logic [ADDR_W-1:0] r_dst;
    logic              r_done;
    logic              r_write;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;

    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic              w_suppress;
    logic [WIDTH-1:0]  w_result;

    assign w_load     = (r_state == IDLE) && start;
    assign w_step     = (r_state == CALC);
    assign w_suppress = (XZR_SUPPRESS != 0) && (r_dst == ADDR_W'(XZR_ADDR));

    mul_shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_op     (op),
        .i_op_a   (opA),
        .i_op_b   (opB),
        .o_last   (w_last),
        .o_result (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dst     <= '0;
            r_done    <= 1'b0;
            r_write   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CALC;
                        r_dst   <= dstAddr;
                    end
                end
                CALC: begin
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    // Sign fix is combinational in the datapath; capture it here.
                    r_state   <= WB;
                    r_done    <= 1'b1;
                    r_write   <= !w_suppress;
                    r_wr_addr <= r_dst;
                    r_wr_data <= w_result;
                end
                WB: begin
                    r_state   <= IDLE;
                    r_done    <= 1'b0;
                    r_write   <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_data <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign write     = r_write;
    assign wrAddr    = r_wr_addr;
    assign wrData    = r_wr_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_writeback_unit.sv
// Self-checking bench for mul_writeback_unit: directed corner cases plus random
// ops compared against a wide-arithmetic reference model.
module tb_mul_writeback_unit;

    localparam int W = 64;
    localparam int A = 5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [A-1:0] dstAddr;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic         write;
    logic [A-1:0] wrAddr;
    logic [W-1:0] wrData;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    mul_writeback_unit #(
        .WIDTH        (W),
        .ADDR_W       (A),
        .XZR_SUPPRESS (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .dstAddr   (dstAddr),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .write     (write),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-width products computed directly with 128-bit arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [127:0]        up;
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        logic signed [127:0] sp;
        up = {64'd0, a} * {64'd0, b};
        sa = $signed({{64{a[63]}}, a});
        sb = $signed({{64{b[63]}}, b});
        sp = sa * sb;
        case (o)
            2'b01:   return up[127:64];
            2'b10:   return sp[127:64];
            default: return up[63:0];
        endcase
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = W'($urandom_range(0, 255));
            2: begin
                case ($urandom_range(0, 4))
                    0: v = 64'h0;
                    1: v = 64'h1;
                    2: v = 64'hFFFF_FFFF_FFFF_FFFF;
                    3: v = 64'h8000_0000_0000_0000;
                    default: v = 64'h7FFF_FFFF_FFFF_FFFF;
                endcase
            end
            default: v = 64'h0 - W'($urandom_range(1, 1000));
        endcase
        return v;
    endfunction

    // Issues one op at a negedge; edge k is the following posedge. The
    // operand bus is scrambled right after acceptance. poke re-asserts start
    // during cycle k+10 with different operands, which must be ignored.
    task automatic run_op(input logic [1:0] op_i, input logic [A-1:0] dst_i,
                          input logic [W-1:0] a_i, input logic [W-1:0] b_i, input bit poke);
        logic [W-1:0] exp_d;
        logic         exp_we;
        @(negedge clk);
        start   = 1'b1;
        op      = op_i;
        dstAddr = dst_i;
        opA     = a_i;
        opB     = b_i;
        exp_q.push_back(ref_result(op_i, a_i, b_i));
        exp_we = (dst_i != 5'd31);
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        dstAddr = A'($urandom);
        opA     = {$urandom, $urandom};
        opB     = {$urandom, $urandom};
        for (int j = 0; j <= 66; j++) begin
            @(negedge clk);
            if (j < 65) begin
                check($sformatf("busy_c%0d", j), busy, 1'b1);
                check($sformatf("quiet_c%0d", j), {write, done}, 2'b00);
            end else if (j == 65) begin
                exp_d = exp_q.pop_front();
                check("wb_done", done, 1'b1);
                check("wb_write", write, exp_we);
                check("wb_addr", wrAddr, dst_i);
                check("wb_data", wrData, exp_d);
                check("wb_busy", busy, 1'b1);
            end else begin
                check("idle_busy", busy, 1'b0);
                check("idle_outs", {done, write, wrAddr, wrData}, '0);
            end
            if (poke && j == 10) begin
                start = 1'b1;
                opA   = 64'd1234;
                opB   = 64'd5678;
                op    = 2'b00;
            end
            if (poke && j == 11) start = 1'b0;
        end
        if (poke) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                check("poke_no_done", {done, write}, 2'b00);
            end
        end
    endtask

    task automatic run_reset_abort();
        bit saw;
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b00;
        dstAddr = 5'd4;
        opA     = 64'd99;
        opB     = 64'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (31) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {done, write, wrAddr, wrData}, '0);
        check("rst_state", dbg_state, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (write || done || busy) saw = 1'b1;
        end
        check("abort_no_write", saw, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        dstAddr = '0;
        opA     = '0;
        opB     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_outs", {done, write, wrAddr, wrData}, '0);
        check("reset_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 5'd9, 64'd3, 64'd5, 1'b0);
        run_op(2'b01, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(2'b00, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(2'b10, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op(2'b10, 5'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        run_op(2'b11, 5'd6, 64'd12345, 64'd678, 1'b0);
        run_op(2'b00, 5'd7, 64'd0, 64'd0, 1'b0);
        run_op(2'b00, 5'd10, 64'd11, 64'd13, 1'b1);
        run_reset_abort();
        run_op(2'b00, 5'd12, 64'd21, 64'd2, 1'b0);
        run_op(2'b00, 5'd31, 64'd7, 64'd7, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), A'($urandom), rand_operand(), rand_operand(), 1'b0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
